// File: rtl/primitive_binner_pkg.sv
// primitive_binner_pkg: shared screen constants, AABB word layout and binner states.
package primitive_binner_pkg;
   localparam int SCREEN_SIZE = 256;
   localparam int TRIANGLE_DATA_BLOCK_SIZE = 1;

   typedef struct packed {
      logic [7:0] max_y;
      logic [7:0] max_x;
      logic [7:0] min_y;
      logic [7:0] min_x;
   } aabb_t;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_WAIT_FETCH, S_DECODE, S_EMIT, S_WAIT_EMIT, S_FLUSH, S_WAIT_FLUSH, S_DONE
   } state_t;

   function automatic aabb_t unpack_aabb(input logic [31:0] word);
      return aabb_t'(word);
   endfunction
endpackage

// File: rtl/primitive_binner_tile_range.sv
// tile_range: maps an AABB word onto its inclusive tile rectangle and flags inverted boxes.
module tile_range
   import primitive_binner_pkg::*;
#(
   parameter int TILE_SHIFT = 5,
   localparam int TW = $clog2(SCREEN_SIZE) - TILE_SHIFT
) (
   input  logic [31:0]   aabb_word,
   output logic [TW-1:0] tx0,
   output logic [TW-1:0] tx1,
   output logic [TW-1:0] ty0,
   output logic [TW-1:0] ty1,
   output logic          degenerate
);
   aabb_t b;

   assign b = unpack_aabb(aabb_word);
   assign tx0 = TW'(b.min_x >> TILE_SHIFT);
   assign tx1 = TW'(b.max_x >> TILE_SHIFT);
   assign ty0 = TW'(b.min_y >> TILE_SHIFT);
   assign ty1 = TW'(b.max_y >> TILE_SHIFT);
   assign degenerate = (b.min_x > b.max_x) || (b.min_y > b.max_y);
endmodule

// File: rtl/primitive_binner.sv
// primitive_binner: bins triangle AABBs into per-tile lists, then writes the per-tile counts.
module primitive_binner
   import primitive_binner_pkg::*;
#(
   parameter int          TILE_SHIFT   = 5,
   parameter int          MAX_PER_TILE = 16,
   parameter logic [31:0] COUNT_BASE   = 32'h0000_1000
) (
   input  logic        aClock,
   input  logic        aReset,
   input  logic        anExecute,
   input  logic [7:0]  aSize,
   output logic        anOutReady,
   output logic        anOutOverflow,
   output logic [31:0] anOutCacheAddr,
   output logic        anOutCacheEnable,
   input  logic [31:0] aCacheData,
   input  logic        aCacheValid,
   output logic [31:0] anOutBinAddr,
   output logic [31:0] anOutBinData,
   output logic        anOutBinWriteEnable,
   input  logic        aBinWriteValid
);
   localparam int TW = $clog2(SCREEN_SIZE) - TILE_SHIFT;
   localparam int NT = 1 << (2 * TW);
   localparam int MW = $clog2(MAX_PER_TILE);
   localparam int CW = MW + 1;

   state_t          state, state_n, next_tri, adv_state;
   logic [7:0]      size_q, index, index_n, adv_index;
   logic [31:0]     aabb, aabb_n, bin_addr_n, bin_data_n;
   logic [TW-1:0]   tx, ty, tx_n, ty_n, tx0, tx1, ty0, ty1, adv_tx, adv_ty;
   logic [2*TW-1:0] tile, flush_tile, flush_tile_n;
   logic [CW-1:0]   counts [NT];
   logic            degenerate, start, last_tile, full, count_inc;
   logic            ovf_n, cache_en_n, bin_we_n;

   tile_range #(.TILE_SHIFT(TILE_SHIFT)) u_range (
      .aabb_word (aabb),
      .tx0       (tx0),
      .tx1       (tx1),
      .ty0       (ty0),
      .ty1       (ty1),
      .degenerate(degenerate)
   );

   assign anOutReady = (state == S_IDLE) || (state == S_DONE);
   assign anOutCacheAddr = 32'(index) * 32'(TRIANGLE_DATA_BLOCK_SIZE);
   assign start = anExecute && anOutReady;
   assign tile = {ty, tx};
   assign last_tile = (tx == tx1) && (ty == ty1);
   assign full = counts[tile] >= CW'(MAX_PER_TILE);
   assign next_tri = (index + 8'd1 == size_q) ? S_FLUSH : S_FETCH;
   // Raster-order cursor step; wrapping past the last tile retires the triangle.
   assign adv_tx = (tx == tx1) ? tx0 : tx + 1'b1;
   assign adv_ty = (tx == tx1) ? ty + 1'b1 : ty;
   assign adv_state = last_tile ? next_tri : S_EMIT;
   assign adv_index = last_tile ? index + 8'd1 : index;

   always_comb begin
      state_n = state;
      index_n = index;
      aabb_n = aabb;
      tx_n = tx;
      ty_n = ty;
      flush_tile_n = flush_tile;
      ovf_n = anOutOverflow;
      cache_en_n = anOutCacheEnable;
      bin_we_n = anOutBinWriteEnable;
      bin_addr_n = anOutBinAddr;
      bin_data_n = anOutBinData;
      count_inc = 1'b0;
      case (state)
         S_IDLE, S_DONE: if (anExecute) begin
            index_n = '0;
            ovf_n = 1'b0;
            flush_tile_n = '0;
            state_n = (aSize == 8'd0) ? S_FLUSH : S_FETCH;
         end
         S_FETCH: begin
            cache_en_n = 1'b1;
            state_n = S_WAIT_FETCH;
         end
         S_WAIT_FETCH: if (aCacheValid) begin
            aabb_n = aCacheData;
            cache_en_n = 1'b0;
            state_n = S_DECODE;
         end
         S_DECODE: begin
            tx_n = tx0;
            ty_n = ty0;
            index_n = degenerate ? index + 8'd1 : index;
            state_n = degenerate ? next_tri : S_EMIT;
         end
         S_EMIT: if (!full) begin
            bin_addr_n = (32'(tile) << MW) + 32'(counts[tile]);
            bin_data_n = 32'(index);
            bin_we_n = 1'b1;
            state_n = S_WAIT_EMIT;
         end else begin
            ovf_n = 1'b1;
            tx_n = adv_tx;
            ty_n = adv_ty;
            index_n = adv_index;
            state_n = adv_state;
         end
         S_WAIT_EMIT: if (aBinWriteValid) begin
            bin_we_n = 1'b0;
            count_inc = 1'b1;
            tx_n = adv_tx;
            ty_n = adv_ty;
            index_n = adv_index;
            state_n = adv_state;
         end
         S_FLUSH: begin
            bin_addr_n = COUNT_BASE + 32'(flush_tile);
            bin_data_n = 32'(counts[flush_tile]);
            bin_we_n = 1'b1;
            state_n = S_WAIT_FLUSH;
         end
         S_WAIT_FLUSH: if (aBinWriteValid) begin
            bin_we_n = 1'b0;
            flush_tile_n = flush_tile + 1'b1;
            state_n = (flush_tile == (2*TW)'(NT - 1)) ? S_DONE : S_FLUSH;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge aClock or posedge aReset) begin
      if (aReset) begin
         state <= S_IDLE;
         size_q <= '0;
         index <= '0;
         aabb <= '0;
         tx <= '0;
         ty <= '0;
         flush_tile <= '0;
         anOutOverflow <= 1'b0;
         anOutCacheEnable <= 1'b0;
         anOutBinWriteEnable <= 1'b0;
         anOutBinAddr <= '0;
         anOutBinData <= '0;
      end else begin
         state <= state_n;
         size_q <= start ? aSize : size_q;
         index <= index_n;
         aabb <= aabb_n;
         tx <= tx_n;
         ty <= ty_n;
         flush_tile <= flush_tile_n;
         anOutOverflow <= ovf_n;
         anOutCacheEnable <= cache_en_n;
         anOutBinWriteEnable <= bin_we_n;
         anOutBinAddr <= bin_addr_n;
         anOutBinData <= bin_data_n;
      end
   end

   always_ff @(posedge aClock or posedge aReset) begin
      if (aReset) begin
         for (int i = 0; i < NT; i++) counts[i] <= '0;
      end else if (start) begin
         for (int i = 0; i < NT; i++) counts[i] <= '0;
      end else if (count_inc) begin
         counts[tile] <= counts[tile] + 1'b1;
      end
   end
endmodule

// File: tb/tb_primitive_binner.sv
// tb_primitive_binner: drives binning jobs against a delay-configurable memory responder and
// compares every bin/count write, the overflow flag and job latency with a loop-based model.
module tb_primitive_binner;
   logic        aClock, aReset, anExecute, aCacheValid, aBinWriteValid;
   logic [7:0]  aSize;
   logic [31:0] aCacheData;
   logic        anOutReady, anOutOverflow, anOutCacheEnable, anOutBinWriteEnable;
   logic [31:0] anOutCacheAddr, anOutBinAddr, anOutBinData;

   int          vectors = 0, miscompares = 0;
   int          mem_delay = 0;
   logic [31:0] cache_mem [256];
   logic [63:0] got_q[$], exp_q[$];
   logic        exp_ovf;
   int          exp_cyc;

   int          cw, bw, cd, bd;
   logic        pce, pwe;
   logic [31:0] pca;
   logic [63:0] pwd;

   primitive_binner dut (
      .aClock             (aClock),
      .aReset             (aReset),
      .anExecute          (anExecute),
      .aSize              (aSize),
      .anOutReady         (anOutReady),
      .anOutOverflow      (anOutOverflow),
      .anOutCacheAddr     (anOutCacheAddr),
      .anOutCacheEnable   (anOutCacheEnable),
      .aCacheData         (aCacheData),
      .aCacheValid        (aCacheValid),
      .anOutBinAddr       (anOutBinAddr),
      .anOutBinData       (anOutBinData),
      .anOutBinWriteEnable(anOutBinWriteEnable),
      .aBinWriteValid     (aBinWriteValid)
   );

   initial aClock = 1'b0;
   always #5 aClock = ~aClock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Memory responder: valid arrives after a per-request delay; accepted writes are logged.
   initial begin
      cw = 0; bw = 0; cd = 0; bd = 0; pce = 1'b0; pwe = 1'b0; pca = '0; pwd = '0;
      aCacheValid = 1'b0; aBinWriteValid = 1'b0; aCacheData = '0;
      forever begin
         @(negedge aClock);
         if (anOutCacheEnable && pce) check("cache addr stable", anOutCacheAddr, pca);
         if (anOutBinWriteEnable && pwe) check("bin addr/data stable", {anOutBinAddr, anOutBinData}, pwd);
         pce = anOutCacheEnable; pca = anOutCacheAddr;
         pwe = anOutBinWriteEnable; pwd = {anOutBinAddr, anOutBinData};
         if (anOutCacheEnable) begin
            if (cw == 0) cd = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
            aCacheValid = (cw >= cd);
            aCacheData = cache_mem[anOutCacheAddr[7:0]];
            cw++;
         end else begin
            aCacheValid = 1'b0;
            cw = 0;
         end
         if (anOutBinWriteEnable) begin
            if (bw == 0) bd = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
            aBinWriteValid = (bw >= bd);
            if (aBinWriteValid) got_q.push_back({anOutBinAddr, anOutBinData});
            bw++;
         end else begin
            aBinWriteValid = 1'b0;
            bw = 0;
         end
      end
   end

   // Reference: walk each box's tile rectangle in raster order with 16-entry bins, 8x8 grid.
   task automatic build_expected(input int n, input int d);
      int cnt [64];
      int x0, x1, y0, y1, t;
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_cyc = 128 + 64 * d;
      for (int i = 0; i < 64; i++) cnt[i] = 0;
      for (int i = 0; i < n; i++) begin
         x0 = int'(cache_mem[i][7:0]) / 32;
         y0 = int'(cache_mem[i][15:8]) / 32;
         x1 = int'(cache_mem[i][23:16]) / 32;
         y1 = int'(cache_mem[i][31:24]) / 32;
         exp_cyc += 3 + d;
         if (cache_mem[i][7:0] > cache_mem[i][23:16] || cache_mem[i][15:8] > cache_mem[i][31:24]) continue;
         for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
               t = y * 8 + x;
               if (cnt[t] < 16) begin
                  exp_q.push_back({32'(t * 16 + cnt[t]), 32'(i)});
                  cnt[t]++;
                  exp_cyc += 2 + d;
               end else begin
                  exp_ovf = 1'b1;
                  exp_cyc += 1;
               end
            end
      end
      for (int t2 = 0; t2 < 64; t2++) exp_q.push_back({32'h1000 + 32'(t2), 32'(cnt[t2])});
   endtask

   task automatic run_job(input string tag, input int n, input bit poke);
      int cyc, m;
      build_expected(n, mem_delay);
      got_q.delete();
      @(negedge aClock);
      anExecute = 1'b1;
      aSize = 8'(n);
      @(negedge aClock);
      anExecute = 1'b0;
      aSize = 8'($urandom_range(0, 255));
      cyc = 0;
      while (!anOutReady && cyc < 20000) begin
         @(negedge aClock);
         cyc++;
         anExecute = poke && (cyc == 7);
      end
      anExecute = 1'b0;
      check({tag, " ready"}, anOutReady, 1'b1);
      check({tag, " write count"}, 64'(got_q.size()), 64'(exp_q.size()));
      m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) check($sformatf("%s write %0d", tag, i), got_q[i], exp_q[i]);
      check({tag, " overflow"}, anOutOverflow, exp_ovf);
      check({tag, " enables idle"}, {anOutCacheEnable, anOutBinWriteEnable}, 2'b00);
      if (mem_delay >= 0) check({tag, " cycles"}, 64'(cyc), 64'(exp_cyc));
   endtask

   function automatic logic [31:0] rand_box();
      int lo_x, lo_y, hi_x, hi_y;
      lo_x = int'($urandom_range(0, 255));
      lo_y = int'($urandom_range(0, 255));
      hi_x = lo_x + int'($urandom_range(0, 60));
      hi_y = lo_y + int'($urandom_range(0, 60));
      if (hi_x > 255) hi_x = 255;
      if (hi_y > 255) hi_y = 255;
      if ($urandom_range(0, 7) == 0) return {8'(hi_y), 8'(lo_x), 8'(lo_y), 8'(hi_x)};
      return {8'(hi_y), 8'(hi_x), 8'(lo_y), 8'(lo_x)};
   endfunction

   initial begin
      int cyc, n;
      aReset = 1'b1;
      anExecute = 1'b0;
      aSize = '0;
      for (int i = 0; i < 256; i++) cache_mem[i] = '0;
      repeat (3) @(negedge aClock);
      check("reset ready", anOutReady, 1'b1);
      check("reset enables", {anOutCacheEnable, anOutBinWriteEnable}, 2'b00);
      check("reset addr/data", {anOutBinAddr, anOutBinData}, 64'h0);
      check("reset overflow", anOutOverflow, 1'b0);
      aReset = 1'b0;

      cache_mem[0] = 32'h1F1F_0000;
      run_job("single tile", 1, 1'b0);

      cache_mem[0] = {8'd40, 8'd40, 8'd20, 8'd20};
      run_job("four tiles", 1, 1'b1);

      for (int i = 0; i < 17; i++) cache_mem[i] = 32'h0505_0101;
      run_job("bin overflow", 17, 1'b0);

      cache_mem[0] = {8'd0, 8'd10, 8'd0, 8'd50};
      run_job("degenerate", 1, 1'b0);

      mem_delay = 3;
      cache_mem[0] = {8'd40, 8'd40, 8'd20, 8'd20};
      run_job("four tiles slow", 1, 1'b0);

      for (int j = 0; j < 6; j++) begin
         mem_delay = (j % 2 == 0) ? -1 : int'($urandom_range(0, 2));
         n = int'($urandom_range(1, 24));
         for (int i = 0; i < n; i++)
            cache_mem[i] = (i > 0 && $urandom_range(0, 3) == 0) ? cache_mem[i - 1] : rand_box();
         run_job($sformatf("random %0d", j), n, 1'(j % 2));
      end

      mem_delay = 5;
      cache_mem[0] = {8'd40, 8'd40, 8'd20, 8'd20};
      @(negedge aClock);
      anExecute = 1'b1;
      aSize = 8'd1;
      @(negedge aClock);
      anExecute = 1'b0;
      cyc = 0;
      while (!(anOutBinWriteEnable && anOutBinAddr < 32'h1000) && cyc < 100) begin
         @(negedge aClock);
         cyc++;
      end
      check("abort reached emit wait", anOutBinWriteEnable, 1'b1);
      #2 aReset = 1'b1;
      #1;
      check("abort write enable", anOutBinWriteEnable, 1'b0);
      check("abort ready", anOutReady, 1'b1);
      check("abort cache enable", anOutCacheEnable, 1'b0);
      @(negedge aClock);
      aReset = 1'b0;
      mem_delay = 0;
      run_job("empty after abort", 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
